ddr2_rw_scheduler: RTL and testbench

Decides when the DDR2 FIFO state machine may write (input buffer to DRAM) and when it may read (DRAM to output buffer), by driving its writes_en/reads_en inputs. It tracks DRAM occupancy in 32-bit words from burst-completion pulses, applies watermarks with a minimum dwell per direction, and inserts a quiet gap on every direction change. It sits between host control and the DDR2 state machine in the acquisition datapath.

---
 rtl/ddr2_rw_scheduler.sv | 121 ++++++++++++
 tb/tb_ddr2_rw_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_rw_scheduler.sv
// ddr2_rw_scheduler: DDR2 write/read direction scheduler with DRAM fill tracking; optional DDR2_SCHED_MAX_DWELL_EN adds a MAX_DWELL bound
module ddr2_rw_scheduler #(
  parameter int BURST_LEN   = 2,
  parameter int IB_HI_WATER = 512,
  parameter int OB_LO_WATER = 256,
  parameter int MIN_DWELL   = 64,
  parameter int SWITCH_GAP  = 8,
  parameter int FILL_W      = 26,
  parameter int DRAM_CAP    = 2**26-2
`ifdef DDR2_SCHED_MAX_DWELL_EN
  , parameter int MAX_DWELL = 4096
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              calib_done,
  input  logic [9:0]        ib_count,
  input  logic [9:0]        ob_count,
  input  logic              wr_burst_done,
  input  logic              rd_burst_done,
  output logic              writes_en,
  output logic              reads_en,
  output logic [FILL_W-1:0] dram_fill,
  output logic              overflow,
  output logic              underflow_err
);
  typedef enum logic [2:0] {S_CALIB, S_IDLE, S_WRITE, S_READ, S_GAP} state_t;
  localparam logic [9:0] IB_BURST = 10'(BURST_LEN);
  localparam logic [9:0] IB_HI = 10'(IB_HI_WATER);
  localparam logic [9:0] OB_LO = 10'(OB_LO_WATER);
  localparam logic [FILL_W-1:0] F_BURST = FILL_W'(BURST_LEN);
  localparam logic [FILL_W-1:0] F_CAP = FILL_W'(DRAM_CAP);
  localparam logic [15:0] DWELL_MIN = 16'(MIN_DWELL - 1);
  localparam logic [7:0] GAP_LAST = 8'(SWITCH_GAP - 1);
  state_t state_q, state_d, next_q, next_d;
  logic [15:0] dwell_q, dwell_d;
  logic [7:0] gap_q, gap_d;
  logic [FILL_W-1:0] dram_fill_q, dram_fill_d;
  logic writes_en_q, writes_en_d, reads_en_q, reads_en_d;
  logic overflow_q, overflow_d, underflow_err_q, underflow_err_d;
  logic want_wr, want_rd, urgent, dwell_met, dwell_max;
  always_comb begin
    want_wr = ib_count >= IB_BURST && !overflow_q;
    want_rd = ob_count < OB_LO && dram_fill_q >= F_BURST;
    urgent = ib_count >= IB_HI && !overflow_q;
    dwell_met = dwell_q >= DWELL_MIN;
`ifdef DDR2_SCHED_MAX_DWELL_EN
    dwell_max = dwell_q >= 16'(MAX_DWELL - 1);
`else
    dwell_max = 1'b0;
`endif
    dram_fill_d = (wr_burst_done && !rd_burst_done) ? (dram_fill_q >= F_CAP - F_BURST ? F_CAP : dram_fill_q + F_BURST) :
                  (rd_burst_done && !wr_burst_done) ? (dram_fill_q < F_BURST ? '0 : dram_fill_q - F_BURST) : dram_fill_q;
    overflow_d = overflow_q | (dram_fill_d == F_CAP);
    underflow_err_d = underflow_err_q | (rd_burst_done && dram_fill_q < F_BURST);
  end
  always_comb begin
    state_d = state_q;
    next_d = next_q;
    case (state_q)
      S_CALIB: state_d = calib_done ? S_IDLE : S_CALIB;
      S_IDLE: state_d = !enable ? S_IDLE : want_wr ? S_WRITE : want_rd ? S_READ : S_IDLE;
      S_WRITE:
        if (want_rd && ((dwell_met && ib_count < IB_HI) || dwell_max)) begin
          state_d = S_GAP;
          next_d = S_READ;
        end else if (!want_wr || !enable) begin
          state_d = S_GAP;
          next_d = S_IDLE;
        end
      S_READ:
        if (urgent || (dwell_met && want_wr)) begin
          state_d = S_GAP;
          next_d = S_WRITE;
        end else if (!want_rd || !enable) begin
          state_d = S_GAP;
          next_d = S_IDLE;
        end
      S_GAP:
        if (gap_q == GAP_LAST)
          state_d = (next_q == S_WRITE && enable && want_wr) ? S_WRITE :
                    (next_q == S_READ && enable && want_rd) ? S_READ : S_IDLE;
      default: state_d = S_CALIB;
    endcase
    if (!calib_done) state_d = S_CALIB;
    gap_d = (state_q == S_GAP && state_d == S_GAP) ? gap_q + 8'd1 : '0;
    dwell_d = (state_d == state_q && (state_q == S_WRITE || state_q == S_READ)) ?
              (dwell_q == 16'hFFFF ? dwell_q : dwell_q + 16'd1) : '0;
    writes_en_d = state_d == S_WRITE;
    reads_en_d = state_d == S_READ;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CALIB;
      next_q <= S_IDLE;
      dwell_q <= '0;
      gap_q <= '0;
      dram_fill_q <= '0;
      writes_en_q <= 1'b0;
      reads_en_q <= 1'b0;
      overflow_q <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      next_q <= next_d;
      dwell_q <= dwell_d;
      gap_q <= gap_d;
      dram_fill_q <= dram_fill_d;
      writes_en_q <= writes_en_d;
      reads_en_q <= reads_en_d;
      overflow_q <= overflow_d;
      underflow_err_q <= underflow_err_d;
    end
  end
  assign writes_en = writes_en_q;
  assign reads_en = reads_en_q;
  assign dram_fill = dram_fill_q;
  assign overflow = overflow_q;
  assign underflow_err = underflow_err_q;
endmodule

// File: tb/tb_ddr2_rw_scheduler.sv
// tb_ddr2_rw_scheduler: scenario tasks plus randomized traffic checked against a behavioural scheduler model
module tb_ddr2_rw_scheduler;
  localparam int BL = 2, HI = 512, LO = 256, MIN = 64, GAP = 8, CAP = 64;
`ifdef DDR2_SCHED_MAX_DWELL_EN
  localparam int MAXD = 100;
`endif
  localparam int CAL = 0, IDL = 1, WR = 2, RD = 3, GP = 4;
  logic clk = 0, reset_n = 0, enable = 0, calib_done = 0, wr_burst_done = 0, rd_burst_done = 0;
  logic [9:0] ib_count = 0, ob_count = 0;
  logic writes_en, reads_en, overflow, underflow_err;
  logic [25:0] dram_fill;
  int errors = 0, checks = 0;
  int m_mode, m_since, m_tgt, m_fill;
  bit m_ovf, m_unf;
  logic [29:0] got, expv;
  ddr2_rw_scheduler #(
    .DRAM_CAP(CAP)
`ifdef DDR2_SCHED_MAX_DWELL_EN
    , .MAX_DWELL(MAXD)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .calib_done(calib_done),
    .ib_count(ib_count), .ob_count(ob_count), .wr_burst_done(wr_burst_done),
    .rd_burst_done(rd_burst_done), .writes_en(writes_en), .reads_en(reads_en),
    .dram_fill(dram_fill), .overflow(overflow), .underflow_err(underflow_err)
  );
  always #5 clk = ~clk;
  assign got = {writes_en, reads_en, overflow, underflow_err, dram_fill};
  assign expv = {m_mode == WR, m_mode == RD, m_ovf, m_unf, 26'(m_fill)};
  always @(posedge clk or negedge reset_n) begin
    int nm, nt, f, ib, ob;
    bit ww, wrd, urg, lim;
    if (!reset_n) begin
      m_mode <= CAL;
      m_since <= 0;
      m_tgt <= IDL;
      m_fill <= 0;
      m_ovf <= 0;
      m_unf <= 0;
    end else begin
      ib = int'(ib_count);
      ob = int'(ob_count);
      ww = ib >= BL && !m_ovf;
      wrd = ob < LO && m_fill >= BL;
      urg = ib >= HI && !m_ovf;
      lim = 0;
`ifdef DDR2_SCHED_MAX_DWELL_EN
      lim = m_since >= MAXD - 1;
`endif
      nm = m_mode;
      nt = m_tgt;
      if (!calib_done) nm = CAL;
      else case (m_mode)
        CAL: nm = IDL;
        IDL: if (enable) nm = ww ? WR : wrd ? RD : IDL;
        WR: if (wrd && ((m_since >= MIN - 1 && ib < HI) || lim)) begin nm = GP; nt = RD; end
            else if (!ww || !enable) begin nm = GP; nt = IDL; end
        RD: if (urg || (m_since >= MIN - 1 && ww)) begin nm = GP; nt = WR; end
            else if (!wrd || !enable) begin nm = GP; nt = IDL; end
        default: if (m_since == GAP - 1) nm = (nt == WR && enable && ww) ? WR : (nt == RD && enable && wrd) ? RD : IDL;
      endcase
      f = m_fill + (wr_burst_done ? BL : 0) - (rd_burst_done ? BL : 0);
      if (f < 0) f = 0;
      if (f > CAP) f = CAP;
      m_since <= (nm == m_mode) ? m_since + 1 : 0;
      m_mode <= nm;
      m_tgt <= nt;
      m_fill <= f;
      m_ovf <= m_ovf || f == CAP;
      m_unf <= m_unf || (rd_burst_done && m_fill < BL);
    end
  end
  task automatic test_reset();
    reset_n = 0; calib_done = 0; enable = 0; ib_count = 0; ob_count = 0;
    repeat (2) @(negedge clk);
    checks++; if (got !== 30'd0) begin errors++; $display("FAIL reset_outputs: got=%h exp=%h", got, 30'd0); end
    reset_n = 1;
    repeat (2) begin
      @(negedge clk);
      checks++; if (got !== expv) begin errors++; $display("FAIL reset_model: got=%h exp=%h", got, expv); end
    end
  endtask
  task automatic test_write();
    calib_done = 1; enable = 1; ib_count = 4; ob_count = 1000;
    @(negedge clk);
    checks++; if (writes_en !== 1'b0) begin errors++; $display("FAIL wr_entry_early: got=%b exp=0", writes_en); end
    @(negedge clk);
    checks++; if (writes_en !== 1'b1) begin errors++; $display("FAIL wr_entry: got=%b exp=1", writes_en); end
    repeat (3) begin
      wr_burst_done = 1;
      @(negedge clk);
      wr_burst_done = 0;
      checks++; if (got !== expv) begin errors++; $display("FAIL wr_pulse_model: got=%h exp=%h", got, expv); end
    end
    checks++; if (dram_fill !== 26'd6) begin errors++; $display("FAIL wr_fill: got=%0d exp=6", dram_fill); end
  endtask
  task automatic test_write_to_read();
    int n;
    repeat (70) begin
      @(negedge clk);
      checks++; if (got !== expv) begin errors++; $display("FAIL w2r_dwell_model: got=%h exp=%h", got, expv); end
    end
    ib_count = 0; ob_count = 10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checks++; if (got !== expv) begin errors++; $display("FAIL w2r_gap_model: got=%h exp=%h", got, expv); end
    end while (reads_en !== 1'b1 && n < 30);
    checks++; if (n != 9) begin errors++; $display("FAIL w2r_gap_len: got=%0d exp=9 edges", n); end
    repeat (3) begin
      rd_burst_done = 1;
      @(negedge clk);
      rd_burst_done = 0;
      checks++; if (got !== expv) begin errors++; $display("FAIL rd_pulse_model: got=%h exp=%h", got, expv); end
    end
    checks++; if (dram_fill !== 26'd0) begin errors++; $display("FAIL rd_fill: got=%0d exp=0", dram_fill); end
    @(negedge clk);
    checks++; if (reads_en !== 1'b0) begin errors++; $display("FAIL rd_exit: got=%b exp=0", reads_en); end
    repeat (12) begin
      @(negedge clk);
      checks++; if (got !== expv) begin errors++; $display("FAIL rd_idle_model: got=%h exp=%h", got, expv); end
    end
  endtask
  task automatic test_urgent();
    int n;
    ob_count = 1000;
    repeat (2) begin
      wr_burst_done = 1;
      @(negedge clk);
      wr_burst_done = 0;
    end
    ob_count = 10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checks++; if (got !== expv) begin errors++; $display("FAIL urg_enter_model: got=%h exp=%h", got, expv); end
    end while (reads_en !== 1'b1 && n < 20);
    if (reads_en !== 1'b1) begin errors++; $display("FAIL urg_read_timeout: got=%b exp=1", reads_en); end
    repeat (5) @(negedge clk);
    ib_count = 600;
    @(negedge clk);
    checks++; if (reads_en !== 1'b0) begin errors++; $display("FAIL urg_drop: got=%b exp=0", reads_en); end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checks++; if (got !== expv) begin errors++; $display("FAIL urg_gap_model: got=%h exp=%h", got, expv); end
    end while (writes_en !== 1'b1 && n < 30);
    checks++; if (n != 8) begin errors++; $display("FAIL urg_gap_len: got=%0d exp=8 edges", n); end
  endtask
  task automatic test_overflow();
    int n;
    ob_count = 1000;
    n = 0;
    while (m_fill < CAP - 2 && n < 40) begin
      wr_burst_done = 1;
      @(negedge clk);
      wr_burst_done = 0;
      n++;
      checks++; if (got !== expv) begin errors++; $display("FAIL ovf_fill_model: got=%h exp=%h", got, expv); end
    end
    wr_burst_done = 1; rd_burst_done = 1;
    @(negedge clk);
    wr_burst_done = 0; rd_burst_done = 0;
    checks++; if (dram_fill !== 26'(CAP - 2)) begin errors++; $display("FAIL both_pulses: got=%0d exp=%0d", dram_fill, CAP - 2); end
    wr_burst_done = 1;
    @(negedge clk);
    wr_burst_done = 0;
    checks++; if ({overflow, dram_fill} !== {1'b1, 26'(CAP)}) begin errors++; $display("FAIL ovf_set: got=%b/%0d exp=1/%0d", overflow, dram_fill, CAP); end
    @(negedge clk);
    checks++; if (writes_en !== 1'b0) begin errors++; $display("FAIL ovf_block: got=%b exp=0", writes_en); end
    n = 0;
    while (m_fill > 0 && n < 40) begin
      rd_burst_done = 1;
      @(negedge clk);
      rd_burst_done = 0;
      n++;
      checks++; if (got !== expv) begin errors++; $display("FAIL drain_model: got=%h exp=%h", got, expv); end
    end
    checks++; if ({underflow_err, dram_fill} !== 27'd0) begin errors++; $display("FAIL drain_end: got=%b/%0d exp=0/0", underflow_err, dram_fill); end
    rd_burst_done = 1;
    @(negedge clk);
    rd_burst_done = 0;
    checks++; if ({underflow_err, overflow, dram_fill} !== {2'b11, 26'd0}) begin errors++; $display("FAIL underflow: got=%b%b/%0d exp=11/0", underflow_err, overflow, dram_fill); end
  endtask
  task automatic test_reset_mid_write();
    int n;
    reset_n = 0;
    @(negedge clk);
    reset_n = 1; calib_done = 1; enable = 1; ib_count = 4; ob_count = 1000;
    n = 0;
    do begin @(negedge clk); n++; end while (writes_en !== 1'b1 && n < 10);
    repeat (5) begin
      wr_burst_done = 1;
      @(negedge clk);
      wr_burst_done = 0;
    end
    checks++; if ({writes_en, dram_fill} !== {1'b1, 26'd10}) begin errors++; $display("FAIL midwr_setup: got=%b/%0d exp=1/10", writes_en, dram_fill); end
    reset_n = 0;
    #1;
    checks++; if (got !== 30'd0) begin errors++; $display("FAIL midwr_async: got=%h exp=%h", got, 30'd0); end
    @(negedge clk);
    checks++; if (got !== 30'd0) begin errors++; $display("FAIL midwr_edge: got=%h exp=%h", got, 30'd0); end
    checks++; if (got !== expv) begin errors++; $display("FAIL midwr_model: got=%h exp=%h", got, expv); end
    reset_n = 1;
  endtask
`ifdef DDR2_SCHED_MAX_DWELL_EN
  task automatic test_max_dwell();
    int n;
    reset_n = 0;
    @(negedge clk);
    reset_n = 1; calib_done = 1; enable = 1; ib_count = 0; ob_count = 1000;
    repeat (2) begin
      wr_burst_done = 1;
      @(negedge clk);
      wr_burst_done = 0;
    end
    repeat (3) @(negedge clk);
    ib_count = 600; ob_count = 10;
    n = 0;
    do @(negedge clk); while (writes_en !== 1'b1 && ++n < 10);
    n = 0;
    while (writes_en === 1'b1 && n < 300) begin
      n++;
      checks++; if (got !== expv) begin errors++; $display("FAIL maxd_model: got=%h exp=%h", got, expv); end
      @(negedge clk);
    end
    checks++; if (n != MAXD) begin errors++; $display("FAIL maxd_len: got=%0d exp=%0d", n, MAXD); end
    n = 0;
    do @(negedge clk); while (reads_en !== 1'b1 && ++n < 20);
    checks++; if (reads_en !== 1'b1) begin errors++; $display("FAIL maxd_read: got=%b exp=1", reads_en); end
  endtask
`endif
  task automatic test_random();
    for (int e = 0; e < 4; e++) begin
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      for (int c = 0; c < 1000; c++) begin
        calib_done = $urandom_range(0, 299) != 0;
        enable = $urandom_range(0, 31) != 0;
        if (c % 50 == 0) begin
          ib_count = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(512, 1023)) : 10'($urandom_range(0, 40));
          ob_count = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 255)) : 10'($urandom_range(256, 1023));
        end
        wr_burst_done = $urandom_range(0, 3) == 0;
        rd_burst_done = $urandom_range(0, e + 2) == 0;
        @(negedge clk);
        checks++; if (got !== expv) begin errors++; $display("FAIL random_e%0d_c%0d: got=%h exp=%h", e, c, got, expv); end
      end
      wr_burst_done = 0; rd_burst_done = 0;
    end
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_write_to_read();
    test_urgent();
    test_overflow();
    test_reset_mid_write();
`ifdef DDR2_SCHED_MAX_DWELL_EN
    test_max_dwell();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
